// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op encodings and FSM states for the sequential MIPS ALU
package alu_pkg;

    // All sixteen codes are in use. MFHI and MFLO share one code, with b[0]
    // selecting the register (1 = HI, 0 = LO), so that DIVU still fits in 4 bits.
    localparam logic [3:0] OP_AND   = 4'h0;
    localparam logic [3:0] OP_OR    = 4'h1;
    localparam logic [3:0] OP_XOR   = 4'h2;
    localparam logic [3:0] OP_NOR   = 4'h3;
    localparam logic [3:0] OP_ADD   = 4'h4;
    localparam logic [3:0] OP_SUB   = 4'h5;
    localparam logic [3:0] OP_SLT   = 4'h6;
    localparam logic [3:0] OP_SLTU  = 4'h7;
    localparam logic [3:0] OP_SLL   = 4'h8;
    localparam logic [3:0] OP_SRL   = 4'h9;
    localparam logic [3:0] OP_SRA   = 4'hA;
    localparam logic [3:0] OP_MFHL  = 4'hB;
    localparam logic [3:0] OP_MULT  = 4'hC;
    localparam logic [3:0] OP_MULTU = 4'hD;
    localparam logic [3:0] OP_DIV   = 4'hE;
    localparam logic [3:0] OP_DIVU  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Multi-cycle ops occupy the top quarter of the code space.
    function automatic logic is_multi(input logic [3:0] op);
        return op[3:2] == 2'b11;
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - iterative shift-add multiplier / restoring divider, one bit per cycle
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             signed_op,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             last
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] rh_q, rl_q, mb_q, a_q;
    logic [SHW-1:0]   cnt_q;
    logic             active_q, is_div_q, neg_q, neg_rem_q, dz_q;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   sum, shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [2*WIDTH-1:0] prod;

    assign mag_a = (signed_op && a[WIDTH-1]) ? -a : a;
    assign mag_b = (signed_op && b[WIDTH-1]) ? -b : b;

    // Multiply: multiplier shifts out of rl while the product shifts in from rh.
    assign sum = {1'b0, rh_q} + (rl_q[0] ? {1'b0, mb_q} : '0);

    // Divide: remainder in rh, dividend bits shift out of rl as quotient bits shift in.
    assign shifted = {rh_q, rl_q[WIDTH-1]};
    assign ge      = shifted >= {1'b0, mb_q};
    assign diff    = shifted[WIDTH-1:0] - mb_q;

    always_comb begin
        step_hi = sum[WIDTH:1];
        step_lo = {sum[0], rl_q[WIDTH-1:1]};
        if (is_div_q) begin
            step_hi = ge ? diff : shifted[WIDTH-1:0];
            step_lo = {rl_q[WIDTH-2:0], ge};
        end
    end

    // Outputs reflect the step in progress so the top can latch them on the last cycle.
    assign prod = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};

    always_comb begin
        hi_out = prod[2*WIDTH-1:WIDTH];
        lo_out = prod[WIDTH-1:0];
        if (is_div_q) begin
            lo_out = neg_q ? -step_lo : step_lo;
            hi_out = neg_rem_q ? -step_hi : step_hi;
            if (dz_q) begin
                lo_out = '1;
                hi_out = a_q;
            end
        end
    end

    assign last = active_q && (cnt_q == SHW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            rh_q      <= '0;
            rl_q      <= '0;
            mb_q      <= '0;
            a_q       <= '0;
            cnt_q     <= '0;
            active_q  <= 1'b0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else if (go) begin
            rh_q      <= '0;
            rl_q      <= mag_a;
            mb_q      <= mag_b;
            a_q       <= a;
            cnt_q     <= '0;
            active_q  <= 1'b1;
            is_div_q  <= is_div;
            neg_q     <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_q <= signed_op && a[WIDTH-1];
            dz_q      <= (b == '0);
        end else if (active_q) begin
            rh_q  <= step_hi;
            rl_q  <= step_lo;
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - execute-stage ALU with single-cycle ops and iterative mult/div into HI/LO
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alucont,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int SHW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, hi_q, lo_q;
    logic             zero_q, done_q;

    logic             accept, go;
    logic [WIDTH-1:0] core;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] md_hi, md_lo;
    logic             md_last;

    assign accept = start && (state_q != ST_RUN);
    assign go     = accept && is_multi(alucont);
    assign shamt  = b[SHW-1:0];

    always_comb begin
        core = '0;
        case (alucont)
            OP_AND:  core = a & b;
            OP_OR:   core = a | b;
            OP_XOR:  core = a ^ b;
            OP_NOR:  core = ~(a | b);
            OP_ADD:  core = a + b;
            OP_SUB:  core = a - b;
            OP_SLT:  core = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: core = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  core = a << shamt;
            OP_SRL:  core = a >> shamt;
            OP_SRA:  core = $signed(a) >>> shamt;
            // hi_q/lo_q already hold the freshly written values during the DONE cycle.
            OP_MFHL: core = b[0] ? hi_q : lo_q;
            default: core = '0;
        endcase
    end

    alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .reset     (reset),
        .go        (go),
        .signed_op (alucont == OP_MULT || alucont == OP_DIV),
        .is_div    (alucont[1]),
        .a         (a),
        .b         (b),
        .hi_out    (md_hi),
        .lo_out    (md_lo),
        .last      (md_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: state_d = go ? ST_RUN : ST_IDLE;
            ST_RUN:           state_d = md_last ? ST_DONE : ST_RUN;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            if (accept && !is_multi(alucont)) begin
                result_q <= core;
                zero_q   <= (core == '0);
                done_q   <= 1'b1;
            end
            if (state_q == ST_RUN && md_last) begin
                hi_q   <= md_hi;
                lo_q   <= md_lo;
                done_q <= 1'b1;
            end
        end
    end

    assign result = result_q;
    assign zero   = zero_q;
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign busy   = (state_q == ST_RUN);
    assign done   = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [3:0]  alucont;
    logic [31:0] a, b;
    logic [31:0] result, hi, lo;
    logic        zero, busy, done;

    int n_err = 0;
    int n_chk = 0;
    int cyc, nbusy, ndone;

    alu_seq #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .alucont (alucont),
        .a       (a),
        .b       (b),
        .result  (result),
        .zero    (zero),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the cycle after the start cycle.
    task automatic issue(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
        alucont = op;
        a       = va;
        b       = vb;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Entered in the cycle after accept (cyc=1); stops in the done cycle or at the bound.
    task automatic wait_done(output int c, output int nb);
        c  = 1;
        nb = 0;
        while (done !== 1'b1 && c < 200) begin
            if (busy === 1'b1) nb++;
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; alucont = OP_AND; a = '0; b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_result", result, 32'h0);
        chk("rst_zero",   {31'b0, zero}, 32'h1);
        chk("rst_hi",     hi, 32'h0);
        chk("rst_lo",     lo, 32'h0);
        chk("rst_busy",   {31'b0, busy}, 32'h0);
        chk("rst_done",   {31'b0, done}, 32'h0);

        // Single-cycle ops
        issue(OP_ADD, 32'h7FFF_FFFF, 32'h1);
        chk("add_done",   {31'b0, done}, 32'h1);
        chk("add_result", result, 32'h8000_0000);
        chk("add_zero",   {31'b0, zero}, 32'h0);
        @(negedge clk);
        chk("add_done_pulse", {31'b0, done}, 32'h0);
        issue(OP_SUB, 32'h5, 32'h5);
        chk("sub_result", result, 32'h0);
        chk("sub_zero",   {31'b0, zero}, 32'h1);
        issue(OP_SLT, 32'hFFFF_FFFF, 32'h1);
        chk("slt",  result, 32'h1);
        issue(OP_SLTU, 32'hFFFF_FFFF, 32'h1);
        chk("sltu", result, 32'h0);
        issue(OP_NOR, 32'h0F0F_0000, 32'h0000_00F0);
        chk("nor",  result, 32'hF0F0_FF0F);
        issue(OP_SLL, 32'h1, 32'h0000_003F);
        chk("sll",  result, 32'h8000_0000);
        issue(OP_SRL, 32'h8000_0000, 32'h4);
        chk("srl",  result, 32'h0800_0000);
        issue(OP_SRA, 32'h8000_0000, 32'h4);
        chk("sra",  result, 32'hF800_0000);

        // MULT: busy 32 cycles, done 33 cycles after start
        issue(OP_MULT, 32'hFFFF_FFFD, 32'h7);
        chk("mult_busy1", {31'b0, busy}, 32'h1);
        chk("mult_done1", {31'b0, done}, 32'h0);
        wait_done(cyc, nbusy);
        chk("mult_lat",   cyc, 33);
        chk("mult_nbusy", nbusy, 32);
        chk("mult_busy_end", {31'b0, busy}, 32'h0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFEB);
        chk("mult_result_kept", result, 32'hF800_0000);
        issue(OP_MFHL, 32'h0, 32'h0);
        chk("mflo", result, 32'hFFFF_FFEB);
        issue(OP_MFHL, 32'h0, 32'h1);
        chk("mfhi", result, 32'hFFFF_FFFF);

        // Divides
        issue(OP_DIV, 32'hFFFF_FFF9, 32'h2);
        wait_done(cyc, nbusy);
        chk("div_lat", cyc, 33);
        chk("div_lo",  lo, 32'hFFFF_FFFD);
        chk("div_hi",  hi, 32'hFFFF_FFFF);
        issue(OP_DIVU, 32'h7, 32'h0);
        wait_done(cyc, nbusy);
        chk("divz_lat", cyc, 33);
        chk("divz_lo",  lo, 32'hFFFF_FFFF);
        chk("divz_hi",  hi, 32'h7);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc, nbusy);
        chk("divmin_lat", cyc, 33);
        chk("divmin_lo",  lo, 32'h8000_0000);
        chk("divmin_hi",  hi, 32'h0);

        // Starts during RUN are ignored; the one still held in the DONE cycle is taken
        issue(OP_MULT, 32'h3, 32'h5);
        alucont = OP_MULTU; a = 32'hFFFF_FFFF; b = 32'h2; start = 1'b1;
        wait_done(cyc, nbusy);
        chk("ign_lat", cyc, 33);
        chk("ign_hi",  hi, 32'h0);
        chk("ign_lo",  lo, 32'hF);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", {31'b0, busy}, 32'h1);
        chk("b2b_done", {31'b0, done}, 32'h0);
        wait_done(cyc, nbusy);
        chk("b2b_lat", cyc, 33);
        chk("b2b_hi",  hi, 32'h1);
        chk("b2b_lo",  lo, 32'hFFFF_FFFE);

        // Reset in the middle of a DIV
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_hi",   hi, 32'h0);
        chk("abort_lo",   lo, 32'h0);
        chk("abort_result", result, 32'h0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) ndone++;
            @(negedge clk);
        end
        chk("abort_no_done", ndone, 0);
        issue(OP_ADD, 32'h2, 32'h3);
        chk("post_add",      result, 32'h5);
        chk("post_add_done", {31'b0, done}, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
